// File: rtl/cpu_axi_master_pkg.sv
// Shared constants for cpu_axi_master: FSM state encoding, fixed AXI field values
// and the AXI3-style sideband widths used by the bus interface.
package cpu_axi_master_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RD_AR  = 3'd1;
  localparam state_t ST_RD_R   = 3'd2;
  localparam state_t ST_WR_REQ = 3'd3;
  localparam state_t ST_WR_B   = 3'd4;

  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_LOCK_W  = 2;
  localparam int AXI_CACHE_W = 4;
  localparam int AXI_PROT_W  = 3;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

  function automatic logic resp_is_err(input logic [AXI_RESP_W-1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/cpu_axi_master_if.sv
// AXI master bus between cpu_axi_master and the downstream axi_sram_bridge.
// The master modport drives AR/AW/W and the R/B readies; slave is the mirror.
interface cpu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) ();
  import cpu_axi_master_pkg::*;

  logic [ID_W-1:0]        arid;
  logic [ADDR_W-1:0]      araddr;
  logic [AXI_LEN_W-1:0]   arlen;
  logic [AXI_SIZE_W-1:0]  arsize;
  logic [AXI_BURST_W-1:0] arburst;
  logic [AXI_LOCK_W-1:0]  arlock;
  logic [AXI_CACHE_W-1:0] arcache;
  logic [AXI_PROT_W-1:0]  arprot;
  logic                   arvalid;
  logic                   arready;

  logic [ID_W-1:0]        rid;
  logic [DATA_W-1:0]      rdata;
  logic [AXI_RESP_W-1:0]  rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  logic [ID_W-1:0]        awid;
  logic [ADDR_W-1:0]      awaddr;
  logic [AXI_LEN_W-1:0]   awlen;
  logic [AXI_SIZE_W-1:0]  awsize;
  logic [AXI_BURST_W-1:0] awburst;
  logic [AXI_LOCK_W-1:0]  awlock;
  logic [AXI_CACHE_W-1:0] awcache;
  logic [AXI_PROT_W-1:0]  awprot;
  logic                   awvalid;
  logic                   awready;

  logic [ID_W-1:0]        wid;
  logic [DATA_W-1:0]      wdata;
  logic [DATA_W/8-1:0]    wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;

  logic [ID_W-1:0]        bid;
  logic [AXI_RESP_W-1:0]  bresp;
  logic                   bvalid;
  logic                   bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cpu_axi_master_wr_chan.sv
// Write address/data channel tracker: AW and W may complete in either order or
// together; both_done fires in the cycle the second of the two handshakes lands.
module cpu_axi_master_wr_chan (
  input  logic aclk,
  input  logic aresetn,
  input  logic active,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic both_done
);

  logic aw_done_r;
  logic w_done_r;
  logic aw_hs_s;
  logic w_hs_s;

  // Valids are pure decodes of registered state, so never depend on *ready
  assign awvalid = active & ~aw_done_r;
  assign wvalid  = active & ~w_done_r;

  // Handshake detection and combined completion
  always_comb begin
    aw_hs_s   = awvalid & awready;
    w_hs_s    = wvalid & wready;
    both_done = active & (aw_done_r | aw_hs_s) & (w_done_r | w_hs_s);
  end

  // Per-channel done flags, cleared together once the pair completes
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else if (both_done) begin
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      aw_done_r <= aw_done_r | aw_hs_s;
      w_done_r  <= w_done_r | w_hs_s;
    end
  end

endmodule

// File: rtl/cpu_axi_master.sv
// Single-outstanding bridge from the CPU req/addr_ok/data_ok interface to AXI.
// Define CPU_AXI_ERR_EN to add cpu_err, flagging a non-OKAY rresp/bresp.
module cpu_axi_master
  import cpu_axi_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cpu_req,
  input  logic                cpu_wr,
  input  logic [1:0]          cpu_size,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic                cpu_addr_ok,
  output logic                cpu_data_ok,
  output logic [DATA_W-1:0]   cpu_rdata,
`ifdef CPU_AXI_ERR_EN
  output logic                cpu_err,
`endif
  cpu_axi_master_if.master    m
);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [1:0]          size_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W/8-1:0] wstrb_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                data_ok_r;
  logic                accept_s;
  logic                ar_hs_s;
  logic                r_hs_s;
  logic                b_hs_s;
  logic                wr_active_s;
  logic                both_done_s;
  logic                bus_unused_s;

  // Acceptance is combinational on cpu_req so back-to-back requests need no bubble
  assign accept_s    = aresetn & cpu_req & (state_r == ST_IDLE);
  assign cpu_addr_ok = accept_s;
  assign cpu_data_ok = data_ok_r;
  assign cpu_rdata   = rdata_r;

  assign ar_hs_s     = m.arvalid & m.arready;
  assign r_hs_s      = m.rvalid & m.rready;
  assign b_hs_s      = m.bvalid & m.bready;
  assign wr_active_s = (state_r == ST_WR_REQ);

  assign m.arvalid = (state_r == ST_RD_AR);
  assign m.rready  = (state_r == ST_RD_R);
  assign m.bready  = (state_r == ST_WR_B);

  assign m.arid    = {ID_W{1'b0}};
  assign m.araddr  = addr_r;
  assign m.arlen   = {AXI_LEN_W{1'b0}};
  assign m.arsize  = {1'b0, size_r};
  assign m.arburst = AXI_BURST_INCR;
  assign m.arlock  = {AXI_LOCK_W{1'b0}};
  assign m.arcache = {AXI_CACHE_W{1'b0}};
  assign m.arprot  = {AXI_PROT_W{1'b0}};

  assign m.awid    = {ID_W{1'b0}};
  assign m.awaddr  = addr_r;
  assign m.awlen   = {AXI_LEN_W{1'b0}};
  assign m.awsize  = {1'b0, size_r};
  assign m.awburst = AXI_BURST_INCR;
  assign m.awlock  = {AXI_LOCK_W{1'b0}};
  assign m.awcache = {AXI_CACHE_W{1'b0}};
  assign m.awprot  = {AXI_PROT_W{1'b0}};

  assign m.wid     = {ID_W{1'b0}};
  assign m.wdata   = wdata_r;
  assign m.wstrb   = wstrb_r;
  assign m.wlast   = 1'b1;

  cpu_axi_master_wr_chan u_wr_chan (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .active    (wr_active_s),
    .awready   (m.awready),
    .wready    (m.wready),
    .awvalid   (m.awvalid),
    .wvalid    (m.wvalid),
    .both_done (both_done_s)
  );

  // Next-state logic for the single-outstanding transaction sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = cpu_wr ? ST_WR_REQ : ST_RD_AR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD_AR: begin
        if (ar_hs_s) state_nxt_s = ST_RD_R;
        else         state_nxt_s = ST_RD_AR;
      end
      ST_RD_R: begin
        if (r_hs_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_RD_R;
      end
      ST_WR_REQ: begin
        if (both_done_s) state_nxt_s = ST_WR_B;
        else             state_nxt_s = ST_WR_REQ;
      end
      ST_WR_B: begin
        if (b_hs_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_WR_B;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Request capture; the CPU may drop or change its fields right after addr_ok
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_r  <= {ADDR_W{1'b0}};
      size_r  <= 2'b00;
      wdata_r <= {DATA_W{1'b0}};
      wstrb_r <= {(DATA_W/8){1'b0}};
    end else if (accept_s) begin
      addr_r  <= cpu_addr;
      size_r  <= cpu_size;
      wdata_r <= cpu_wdata;
      wstrb_r <= cpu_wstrb;
    end
  end

  // Response path: read data holds until the next read completes
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_r   <= {DATA_W{1'b0}};
      data_ok_r <= 1'b0;
    end else begin
      if (r_hs_s) rdata_r <= m.rdata;
      data_ok_r <= r_hs_s | b_hs_s;
    end
  end

`ifdef CPU_AXI_ERR_EN
  logic err_r;

  assign cpu_err = err_r;

  // Error flag rides alongside data_ok so it is only ever high with it
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) err_r <= 1'b0;
    else          err_r <= (r_hs_s & resp_is_err(m.rresp)) | (b_hs_s & resp_is_err(m.bresp));
  end

  assign bus_unused_s = ^{m.rid, m.rlast, m.bid};
`else
  assign bus_unused_s = ^{m.rid, m.rlast, m.bid, m.rresp, m.bresp};
`endif

endmodule

// File: tb/tb_cpu_axi_master.sv
// Randomized bench for cpu_axi_master: a transaction-level model predicts
// every CPU and AXI output each cycle against a reactive AXI slave model.
`timescale 1ns/1ps
module tb_cpu_axi_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
  } op_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cpu_req;
  logic        cpu_wr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;
  logic [31:0] cpu_rdata;
`ifdef CPU_AXI_ERR_EN
  logic        cpu_err;
`endif

  always #5 aclk = ~aclk;

  cpu_axi_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

  cpu_axi_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cpu_req     (cpu_req),
    .cpu_wr      (cpu_wr),
    .cpu_size    (cpu_size),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wstrb   (cpu_wstrb),
    .cpu_addr_ok (cpu_addr_ok),
    .cpu_data_ok (cpu_data_ok),
    .cpu_rdata   (cpu_rdata),
`ifdef CPU_AXI_ERR_EN
    .cpu_err     (cpu_err),
`endif
    .m           (axi)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit abort = 1'b0;

  // transaction-level model of the master
  op_t         pend_q[$];
  op_t         drv_op;
  bit          drv_valid = 1'b0;
  bit          gap_rand  = 1'b0;
  op_t         cur;
  bit          active, ar_seen, aw_seen, w_seen;
  bit          done_pulse, done_wr, done_err;
  logic [31:0] done_rdata;
  logic [31:0] ref_mem [16];

  // slave model
  logic [31:0] slv_mem [16];
  bit          fast = 1'b1, w_lag = 1'b0, stall_r = 1'b0;
  int          resp_mode = 0;
  bit          r_pend, b_pend, aw_got, w_got;
  int          r_dly, b_dly, aw_at;
  logic [31:0] r_dat, aw_a_r, w_d_r;
  logic [3:0]  w_s_r;
  logic [1:0]  r_resp, b_resp;

  int          acc_cyc[$];
  int          done_cyc[$];
  logic [31:0] rd_log[$];
  int          err_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [1:0] pick_resp();
    if (resp_mode == 1) return 2'($urandom_range(0, 3));
    else if (resp_mode == 2) return 2'b10;
    else return 2'b00;
  endfunction

  task automatic reset_models();
    active = 1'b0; ar_seen = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
    done_pulse = 1'b0; done_wr = 1'b0; done_err = 1'b0; done_rdata = 32'd0;
    drv_valid = 1'b0;
    r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
    r_dly = 0; b_dly = 0; aw_at = 0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'd0; cpu_addr = 32'd0;
    cpu_wdata = 32'd0; cpu_wstrb = 4'd0;
    axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.rvalid = 1'b0; axi.rdata = 32'd0; axi.rresp = 2'd0; axi.rid = 4'd0; axi.rlast = 1'b1;
    axi.bvalid = 1'b0; axi.bresp = 2'd0; axi.bid = 4'd0;
  endtask

  // one clock: check at negedge, then advance model/slave/CPU just after posedge
  task automatic cycle();
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, acc;
    logic [1:0]  rr, br;
    logic [31:0] ar_a, aw_a, w_d;
    logic [3:0]  w_s;
    @(negedge aclk);
    ar_hs = axi.arvalid & axi.arready;
    r_hs  = axi.rvalid & axi.rready;
    aw_hs = axi.awvalid & axi.awready;
    w_hs  = axi.wvalid & axi.wready;
    b_hs  = axi.bvalid & axi.bready;
    acc   = cpu_req & !active;
    rr = axi.rresp; br = axi.bresp;
    ar_a = axi.araddr; aw_a = axi.awaddr; w_d = axi.wdata; w_s = axi.wstrb;

    chk("addr_ok", cpu_addr_ok, acc);
    chk("data_ok", cpu_data_ok, done_pulse);
    if (done_pulse && !done_wr) chk("rdata", cpu_rdata, done_rdata);
`ifdef CPU_AXI_ERR_EN
    chk("cpu_err", cpu_err, done_pulse & done_err);
    if (cpu_err) err_cnt++;
`endif
    chk("arvalid", axi.arvalid, active & !cur.wr & !ar_seen);
    chk("rready",  axi.rready,  active & !cur.wr & ar_seen);
    chk("awvalid", axi.awvalid, active & cur.wr & !aw_seen);
    chk("wvalid",  axi.wvalid,  active & cur.wr & !w_seen);
    chk("bready",  axi.bready,  active & cur.wr & aw_seen & w_seen);
    if (ar_hs) begin
      chk("araddr", ar_a, cur.addr);
      chk("arsize", axi.arsize, {1'b0, cur.size});
      chk("ar_fixed", {axi.arid, axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot},
          {4'd0, 8'd0, 2'b01, 2'd0, 4'd0, 3'd0});
    end
    if (aw_hs) begin
      chk("awaddr", aw_a, cur.addr);
      chk("awsize", axi.awsize, {1'b0, cur.size});
      chk("aw_fixed", {axi.awid, axi.awlen, axi.awburst, axi.awlock, axi.awcache, axi.awprot},
          {4'd0, 8'd0, 2'b01, 2'd0, 4'd0, 3'd0});
    end
    if (w_hs) begin
      chk("wdata", w_d, cur.wdata);
      chk("wstrb", w_s, cur.wstrb);
      chk("w_fixed", {axi.wid, axi.wlast}, {4'd0, 1'b1});
    end
    if (cpu_addr_ok) acc_cyc.push_back(cyc);
    if (cpu_data_ok) begin
      done_cyc.push_back(cyc);
      if (!done_wr) rd_log.push_back(cpu_rdata);
    end

    @(posedge aclk);
    #1;
    cyc++;
    done_pulse = 1'b0;
    if (active && ((r_hs && !cur.wr) || (b_hs && cur.wr))) begin
      done_pulse = 1'b1;
      done_wr    = cur.wr;
      done_rdata = cur.exp_rdata;
      done_err   = cur.wr ? (br != 2'b00) : (rr != 2'b00);
      active     = 1'b0;
    end
    if (ar_hs) ar_seen = 1'b1;
    if (aw_hs) aw_seen = 1'b1;
    if (w_hs)  w_seen  = 1'b1;
    if (acc) begin
      cur = drv_op;
      if (cur.wr) ref_mem[cur.addr[5:2]] = merge(ref_mem[cur.addr[5:2]], cur.wdata, cur.wstrb);
      else        cur.exp_rdata = ref_mem[cur.addr[5:2]];
      active = 1'b1; ar_seen = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
      drv_valid = 1'b0;
    end

    // slave reaction
    if (r_hs) r_pend = 1'b0;
    if (b_hs) b_pend = 1'b0;
    if (ar_hs) begin
      r_pend = 1'b1; r_dat = slv_mem[ar_a[5:2]];
      r_dly = fast ? 0 : int'($urandom_range(0, 3)); r_resp = pick_resp();
    end
    if (aw_hs) begin aw_got = 1'b1; aw_at = cyc; aw_a_r = aw_a; end
    if (w_hs)  begin w_got = 1'b1; w_d_r = w_d; w_s_r = w_s; end
    if (aw_got && w_got) begin
      slv_mem[aw_a_r[5:2]] = merge(slv_mem[aw_a_r[5:2]], w_d_r, w_s_r);
      aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
      b_dly = fast ? 0 : int'($urandom_range(0, 3)); b_resp = pick_resp();
    end
    axi.rvalid = r_pend && (r_dly == 0) && !stall_r;
    axi.rdata  = axi.rvalid ? r_dat : $urandom;
    axi.rresp  = r_resp;
    if (r_pend && r_dly > 0) r_dly--;
    axi.bvalid = b_pend && (b_dly == 0);
    axi.bresp  = b_resp;
    if (b_pend && b_dly > 0) b_dly--;
    axi.arready = fast ? 1'b1 : 1'($urandom_range(0, 1));
    axi.awready = !aw_got && (fast || 1'($urandom_range(0, 1)));
    if (w_lag) axi.wready = !w_got && aw_got && (cyc - aw_at >= 3);
    else       axi.wready = !w_got && (fast || 1'($urandom_range(0, 1)));

    // CPU side
    if (!drv_valid && pend_q.size() > 0 && (!gap_rand || $urandom_range(0, 2) == 0)) begin
      drv_op = pend_q.pop_front();
      drv_valid = 1'b1;
    end
    cpu_req = drv_valid;
    if (drv_valid) begin
      cpu_wr = drv_op.wr; cpu_size = drv_op.size; cpu_addr = drv_op.addr;
      cpu_wdata = drv_op.wdata; cpu_wstrb = drv_op.wstrb;
    end else begin
      cpu_wr = 1'($urandom_range(0, 1)); cpu_addr = $urandom; cpu_wdata = $urandom;
      cpu_size = 2'($urandom_range(0, 3)); cpu_wstrb = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pend_q.size() != 0 || drv_valid || active || done_pulse) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      total++; bad++; abort = 1'b1;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic push_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
    op_t o;
    o.wr = wr; o.addr = addr; o.size = 2'd2; o.wdata = wdata; o.wstrb = wstrb;
    o.exp_rdata = 32'd0;
    pend_q.push_back(o);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    int  n;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'h1111_0000 + 32'(i);
      slv_mem[i] = 32'h1111_0000 + 32'(i);
    end
    ref_mem[0] = 32'hDEAD_BEEF;
    slv_mem[0] = 32'hDEAD_BEEF;
    cur = '0; drv_op = '0;
    reset_models();
    aresetn = 1'b0;
    cpu_req = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 5'b00000);
    chk("rst_addr_ok", cpu_addr_ok, 1'b0);
    chk("rst_data_ok", cpu_data_ok, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    @(posedge aclk);
    #1;
    cpu_req = 1'b0;
    aresetn = 1'b1;

    // directed back-to-back read / write / read at minimum latency
    push_op(1'b0, 32'h0000_0100, 32'd0, 4'd0);
    push_op(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011);
    push_op(1'b0, 32'h0000_0100, 32'd0, 4'd0);
    drain(100);
    chk("model_merge", ref_mem[0], 32'hDEAD_5678);
    chk("b2b_rd_count", rd_log.size(), 2);
    chk("b2b_done_count", done_cyc.size(), 3);
    chk("b2b_acc_count", acc_cyc.size(), 3);
    if (rd_log.size() == 2) begin
      chk("read_preload", rd_log[0], 32'hDEAD_BEEF);
      chk("read_after_strb_write", rd_log[1], 32'hDEAD_5678);
    end
    if (done_cyc.size() == 3 && acc_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("min_latency", done_cyc[i] - acc_cyc[i], 3);
      for (int i = 0; i < 2; i++) chk("b2b_no_bubble", acc_cyc[i+1], done_cyc[i]);
    end

    // write with W accepted three cycles after AW
    acc_cyc.delete(); done_cyc.delete();
    w_lag = 1'b1;
    push_op(1'b1, 32'h0000_0104, 32'hA5A5_5A5A, 4'b1111);
    drain(100);
    w_lag = 1'b0;
    chk("lag_done_count", done_cyc.size(), 1);
    if (done_cyc.size() == 1 && acc_cyc.size() == 1)
      chk("lag_latency", done_cyc[0] - acc_cyc[0], 7);

    // reset while waiting on a stalled R channel
    stall_r = 1'b1;
    push_op(1'b0, 32'h0000_0108, 32'd0, 4'd0);
    n = 0;
    while (!(active && ar_seen) && n < 20) begin cycle(); n++; end
    cycle(); cycle();
    chk("stall_rready", axi.rready, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("arst_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 5'b00000);
    chk("arst_data_ok", cpu_data_ok, 1'b0);
    chk("arst_rdata", cpu_rdata, 32'd0);
    stall_r = 1'b0;
    pend_q.delete();
    reset_models();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rd_log.delete();
    push_op(1'b0, 32'h0000_0100, 32'd0, 4'd0);
    drain(100);
    chk("post_reset_read_count", rd_log.size(), 1);
    if (rd_log.size() == 1) chk("post_reset_read", rd_log[0], 32'hDEAD_5678);

`ifdef CPU_AXI_ERR_EN
    // SLVERR on a write must surface as a single cpu_err pulse
    err_cnt = 0;
    resp_mode = 2;
    push_op(1'b1, 32'h0000_010C, 32'hCAFE_F00D, 4'b1111);
    drain(100);
    chk("err_pulse_count", err_cnt, 1);
`endif

    // randomized traffic with random slave delays and responses
    if (!abort) begin
      fast = 1'b0; resp_mode = 1; gap_rand = 1'b1;
      for (int i = 0; i < 200; i++) begin
        o.wr = 1'($urandom_range(0, 1));
        o.addr = 32'h0000_0100 + 32'($urandom_range(0, 15)) * 32'd4;
        o.size = 2'($urandom_range(0, 2));
        o.wdata = $urandom;
        o.wstrb = 4'($urandom_range(0, 15));
        o.exp_rdata = 32'd0;
        pend_q.push_back(o);
      end
      drain(20000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_axi_master.md
# cpu_axi_master

Single-outstanding AXI master that converts the CPU's simple request/acknowledge SRAM-style interface into single-beat AXI read and write transactions. Sits directly upstream of `axi_sram_bridge` and drives its `m_*` AXI slave port. Captures one request, issues AR or AW+W, waits for R or B, then returns data or acknowledgement to the CPU.

## Interface
Parameters:
- `ADDR_W`, 32, address width; equals `` `Laraddr``/`` `Lawaddr``.
- `DATA_W`, 32, data width; equals `` `Lrdata``/`` `Lwdata``.
- `ID_W`, 4, AXI ID width; all IDs are driven to 0.

Ports:
- Clock and reset: one clock, `aclk`; reset `aresetn` is asynchronous and active-low.
- `cpu_req`  in  1  request valid; held with all `cpu_*` request fields until `cpu_addr_ok`.
- `cpu_wr`  in  1  1 = write, 0 = read.
- `cpu_size`  in  2  bytes = 2^size; passed to `arsize`/`awsize` (upper bit 0).
- `cpu_addr`  in  ADDR_W  byte address.
- `cpu_wdata`  in  DATA_W  write data.
- `cpu_wstrb`  in  DATA_W/8  byte strobes.
- `cpu_addr_ok`  out  1  request accepted this cycle.
- `cpu_data_ok`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  read data, valid with `cpu_data_ok` on reads.
- The full AXI master set, using the bridge's `` `L*`` widths, with directions opposite to the bridge's `m_*` ports: `m_ar*`, `m_r*`, `m_aw*`, `m_w*`, `m_b*`.

## Operation
- FSM states: `IDLE`, `RD_AR`, `RD_R`, `WR_REQ`, `WR_B`.
- `IDLE`: `cpu_addr_ok = cpu_req` (combinational). On the accepting edge, register addr/size/wdata/wstrb. Next state is `WR_REQ` if `cpu_wr`, else `RD_AR`.
- `RD_AR`: `m_arvalid = 1`. On `arvalid & arready`, go to `RD_R`.
- `RD_R`: `m_rready = 1`. On `rvalid & rready`, register `m_rdata` into `cpu_rdata`, set `data_ok_q`, and go to `IDLE`.
- `WR_REQ`: `m_awvalid = ~aw_done` and `m_wvalid = ~w_done`.
  - `aw_done` and `w_done` set on their own handshakes.
  - Handshakes may occur in either order or in the same cycle.
  - When both are done (registered or handshaking this cycle), go to `WR_B` and clear both flags.
- `WR_B`: `m_bready = 1`. On `bvalid & bready`, set `data_ok_q` and go to `IDLE`.
- Fixed AXI fields:
  - `arlen`/`awlen` = 0, burst = INCR (2'b01), cache = 0, lock = 0, prot = 0.
  - `wlast` = 1, all IDs = 0.
  - `wstrb` comes from the captured request.
- The CPU must not change request fields while `cpu_req` is high and `cpu_addr_ok` is low. Behaviour otherwise is undefined.
- Reset (asynchronous, any state): FSM to `IDLE`; `aw_done`, `w_done` and `data_ok_q` cleared; all valid/ready outputs 0; `cpu_rdata` = 0. An in-flight transaction is abandoned and the slave must also be reset.

## Timing
- `cpu_data_ok` = `data_ok_q`: high exactly one cycle, the cycle after the R/B handshake.
  - In that same cycle the FSM is in `IDLE`, so `cpu_addr_ok` may be high concurrently.
  - Back-to-back requests therefore need no bubble.
- Minimum read latency with `axi_sram_bridge`:
  - cycle 0: `addr_ok`.
  - cycle 1: AR handshake.
  - cycle 2: R handshake.
  - cycle 3: `data_ok`.
- Minimum write latency with the bridge:
  - cycle 0: `addr_ok`.
  - cycle 1: AW+W handshakes.
  - cycle 2: `bvalid`/B handshake.
  - cycle 3: `data_ok`.
- Valid outputs never drop before their handshake (AXI rule). `arvalid`/`awvalid`/`wvalid` are registered-state decodes with no combinational path from `*ready`.
- Reset values: `m_arvalid`, `m_awvalid`, `m_wvalid`, `m_rready`, `m_bready`, `cpu_addr_ok`, `cpu_data_ok` all 0; `cpu_rdata` 0.

## Configuration
- `CPU_AXI_ERR_EN` defined: adds output `cpu_err` (1 bit).
  - Registered alongside `data_ok_q`: 1 when the completing `rresp`/`bresp` ≠ 2'b00.
  - Reset 0; 0 whenever `cpu_data_ok` is 0.
- Not defined: no `cpu_err` port; `rresp`/`bresp` are ignored.

## Structure
- Shared package/defines (alongside `defines.vh`):
  - FSM state encoding (3-bit).
  - `AXI_BURST_INCR`, `AXI_RESP_OKAY`.
- Optional sub-module `cpu_axi_wr_chan`: owns `aw_done`/`w_done`, AW/W valid generation and the `both_done` output. The main module keeps the FSM and read path.

## Test plan
- Read with `axi_sram_bridge` plus 1-cycle SRAM preloaded `0x100` = `0xDEADBEEF`:
  - `cpu_req` read addr `0x100` → `addr_ok` at cycle 0, `data_ok` at cycle 3, `cpu_rdata = 0xDEADBEEF`.
- Write `0x100` ← `0x12345678`, `wstrb = 4'b0011`, then read `0x100` → read returns `0xDEAD5678`; each write `data_ok` at cycle 3.
- Write with slave `wready` delayed 3 cycles after `awready` → `awvalid` drops after its handshake, `wvalid` holds until its own; exactly one `data_ok`.
- Back-to-back read, write, read with `cpu_req` held high → the second `addr_ok` coincides with the first `data_ok`; no lost or duplicated handshakes.
- Assert `aresetn` = 0 while in `RD_R` with `rvalid` stalled → all valids/readies 0 immediately; the next request completes normally.
- With `CPU_AXI_ERR_EN`, slave returns `bresp = 2'b10` → `cpu_err = 1` only in the `data_ok` cycle.
